// File: rtl/counter_seq_ctrl.sv
// Run/hold/idle sequencing counter: counts 0..limit per period, one-shot or auto-reload,
// with pause, abort and a saturating count of completed periods.
module counter_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int PCW   = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             paused,
   output logic             done,
   output logic [PCW-1:0]   periods
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [PCW-1:0] PeriodsMax = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;
   logic [PCW-1:0]   periods_q, periods_d;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= IDLE;
         count_q   <= '0;
         lim_q     <= '0;
         mode_q    <= 1'b0;
         done_q    <= 1'b0;
         periods_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         lim_q     <= lim_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         periods_q <= periods_d;
      end
   end

   // Abort outranks pause, and pause outranks the terminal-count check.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      lim_d     = lim_q;
      mode_d    = mode_q;
      done_d    = 1'b0;
      periods_d = periods_q;
      unique case (state_q)
         IDLE: begin
            count_d = '0;
            if (start && !abort) begin
               state_d   = RUN;
               lim_d     = limit;
               mode_d    = auto_reload;
               periods_d = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else if (pause) begin
               state_d = HOLD;
            end else if (count_q == lim_q) begin
               count_d = '0;
               done_d  = 1'b1;
               if (periods_q != PeriodsMax) begin
                  periods_d = periods_q + 1'b1;
               end
               if (!mode_q) begin
                  state_d = IDLE;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         HOLD: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else if (!pause) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   assign count   = count_q;
   assign busy    = (state_q == RUN) || (state_q == HOLD);
   assign paused  = (state_q == HOLD);
   assign done    = done_q;
   assign periods = periods_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: directed cycle vectors push expected outputs,
// a monitor pops one entry after each rising edge and compares.
module tb_counter_seq_ctrl;

   logic       clk;
   logic       clr;
   logic       start;
   logic       pause;
   logic       abort;
   logic       autoReload;
   logic [7:0] limit;
   logic [7:0] count;
   logic       busy;
   logic       paused;
   logic       done;
   logic [7:0] periods;

   typedef struct {
      string      name;
      logic [7:0] count;
      logic       busy;
      logic       paused;
      logic       done;
      logic [7:0] periods;
   } expT;

   expT scoreboard[$];
   int  assertCount = 0;
   int  failCount   = 0;

   counter_seq_ctrl #(.WIDTH(8), .PCW(8)) dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .pause      (pause),
      .abort      (abort),
      .auto_reload(autoReload),
      .limit      (limit),
      .count      (count),
      .busy       (busy),
      .paused     (paused),
      .done       (done),
      .periods    (periods)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge.
   task automatic applyStimulus(input string name, input logic stV, input logic paV, input logic abV,
                                input logic arV, input logic clrV, input logic [7:0] limV,
                                input logic [7:0] eCount, input logic eBusy, input logic ePaused,
                                input logic eDone, input logic [7:0] ePeriods);
      expT e;
      @(negedge clk);
      start      = stV;
      pause      = paV;
      abort      = abV;
      autoReload = arV;
      clr        = clrV;
      limit      = limV;
      e.name     = name;
      e.count    = eCount;
      e.busy     = eBusy;
      e.paused   = ePaused;
      e.done     = eDone;
      e.periods  = ePeriods;
      scoreboard.push_back(e);
   endtask

   task automatic checkOutput(input expT e);
      assertCount++;
      if (count !== e.count || busy !== e.busy || paused !== e.paused ||
          done !== e.done || periods !== e.periods) begin
         failCount++;
         $display("[TB] FAIL %s: got count=%0d busy=%b paused=%b done=%b periods=%0d, expected count=%0d busy=%b paused=%b done=%b periods=%0d",
                  e.name, count, busy, paused, done, periods,
                  e.count, e.busy, e.paused, e.done, e.periods);
      end
   endtask

   // Monitor: every rising edge that has a queued expectation gets compared shortly after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (scoreboard.size() > 0) begin
            checkOutput(scoreboard.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clr = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; autoReload = 1'b0; limit = 8'd0;

      // Two clear cycles.
      applyStimulus("reset0", 0, 0, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, 8'd0);
      applyStimulus("reset1", 0, 0, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, 8'd0);

      // One-shot, limit 5; limit/mode changes after acceptance must not matter.
      applyStimulus("os_start", 1, 0, 0, 0, 0, 8'd5, 8'd0, 1, 0, 0, 8'd0);
      for (int i = 1; i <= 5; i++)
         applyStimulus("os_count", 0, 0, 0, 1, 0, 8'hAA, 8'(i), 1, 0, 0, 8'd0);
      applyStimulus("os_done", 0, 0, 0, 1, 0, 8'hAA, 8'd0, 0, 0, 1, 8'd1);
      applyStimulus("os_idle", 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd1);

      // Auto-reload, limit 3, 12 cycles then abort.
      applyStimulus("ar_start", 1, 0, 0, 1, 0, 8'd3, 8'd0, 1, 0, 0, 8'd0);
      for (int i = 1; i <= 12; i++)
         applyStimulus("ar_count", 0, 0, 0, 0, 0, 8'h55, 8'(i % 4), 1, 0, (i % 4 == 0), 8'(i / 4));
      applyStimulus("ar_abort", 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd3);

      // One-shot limit 10 with a 3-edge pause at count 4.
      applyStimulus("ps_start", 1, 0, 0, 0, 0, 8'd10, 8'd0, 1, 0, 0, 8'd0);
      for (int i = 1; i <= 4; i++)
         applyStimulus("ps_count", 0, 0, 0, 0, 0, 8'd0, 8'(i), 1, 0, 0, 8'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus("ps_hold", 0, 1, 0, 0, 0, 8'd0, 8'd4, 1, 1, 0, 8'd0);
      applyStimulus("ps_release", 0, 0, 0, 0, 0, 8'd0, 8'd4, 1, 0, 0, 8'd0);
      for (int i = 5; i <= 10; i++)
         applyStimulus("ps_resume", 0, 0, 0, 0, 0, 8'd0, 8'(i), 1, 0, 0, 8'd0);
      applyStimulus("ps_done", 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 8'd1);

      // Pause held at terminal count suppresses done until release.
      applyStimulus("pt_start", 1, 0, 0, 0, 0, 8'd2, 8'd0, 1, 0, 0, 8'd0);
      for (int i = 1; i <= 2; i++)
         applyStimulus("pt_count", 0, 0, 0, 0, 0, 8'd0, 8'(i), 1, 0, 0, 8'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus("pt_hold", 0, 1, 0, 0, 0, 8'd0, 8'd2, 1, 1, 0, 8'd0);
      applyStimulus("pt_release", 0, 0, 0, 0, 0, 8'd0, 8'd2, 1, 0, 0, 8'd0);
      applyStimulus("pt_done", 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 8'd1);

      // Start together with abort in IDLE is ignored.
      applyStimulus("idle_abort_start", 1, 0, 1, 0, 0, 8'd4, 8'd0, 0, 0, 0, 8'd1);

      // Pause and abort on the same RUN edge.
      applyStimulus("pa_start", 1, 0, 0, 0, 0, 8'd5, 8'd0, 1, 0, 0, 8'd0);
      applyStimulus("pa_count", 0, 0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 0, 8'd0);
      applyStimulus("pa_abort", 0, 1, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0);

      // Auto-reload limit 200, a start while busy, abort at count 50.
      applyStimulus("ab_start", 1, 0, 0, 1, 0, 8'd200, 8'd0, 1, 0, 0, 8'd0);
      for (int i = 1; i <= 50; i++)
         applyStimulus("ab_count", (i == 10), 0, 0, 0, 0, (i == 10) ? 8'd9 : 8'd0, 8'(i), 1, 0, 0, 8'd0);
      applyStimulus("ab_abort", 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0);
      applyStimulus("ab_idle", 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0);

      // Abort while in HOLD.
      applyStimulus("ah_start", 1, 0, 0, 1, 0, 8'd7, 8'd0, 1, 0, 0, 8'd0);
      applyStimulus("ah_count", 0, 0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 0, 8'd0);
      applyStimulus("ah_hold", 0, 1, 0, 0, 0, 8'd0, 8'd1, 1, 1, 0, 8'd0);
      applyStimulus("ah_abort", 0, 1, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0);

      // Limit 0 auto-reload: done every cycle, periods saturates at 255, then clr mid-run.
      applyStimulus("z_start", 1, 0, 0, 1, 0, 8'd0, 8'd0, 1, 0, 0, 8'd0);
      for (int i = 1; i <= 258; i++)
         applyStimulus("z_period", 0, 0, 0, 0, 0, 8'd0, 8'd0, 1, 0, 1, (i > 255) ? 8'd255 : 8'(i));
      applyStimulus("z_clr", 1, 0, 0, 1, 1, 8'd3, 8'd0, 0, 0, 0, 8'd0);

      // First start after clr is accepted with no extra latency.
      applyStimulus("rs_start", 1, 0, 0, 0, 0, 8'd1, 8'd0, 1, 0, 0, 8'd0);
      applyStimulus("rs_count", 0, 0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 0, 8'd0);
      applyStimulus("rs_done", 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, 8'd1);

      // clr while in HOLD with pause still high.
      applyStimulus("ch_start", 1, 0, 0, 1, 0, 8'd7, 8'd0, 1, 0, 0, 8'd0);
      applyStimulus("ch_count", 0, 0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 0, 8'd0);
      applyStimulus("ch_hold", 0, 1, 0, 0, 0, 8'd0, 8'd1, 1, 1, 0, 8'd0);
      applyStimulus("ch_clr", 0, 1, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, 8'd0);
      applyStimulus("ch_after", 0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0, 8'd0);

      for (int i = 0; i < 20 && scoreboard.size() > 0; i++)
         @(posedge clk);
      #2;
      if (scoreboard.size() > 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", scoreboard.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
